qproc_mem_seq: RTL and testbench

QPROC_MEM_SEQ -- requirements
Module: qproc_mem_seq

---
 rtl/qproc_mem_seq.sv | 182 ++++++++++++++++++
 tb/tb_qproc_mem_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qproc_mem_seq.sv
// qproc_mem_seq: single-port memory transfer sequencer.
//
// A start pulse launches a burst of len_i words from addr_i. Writes take words
// from a valid/ready stream and push them to the memory port in the
// handshake cycle. Reads issue one access at a time, wait RD_LAT cycles,
// then present the word on a valid/ready stream.
//
// Parameters: AW (address width), DW (data width), RD_LAT (1-4, memory read
// latency in cycles from mem_en_o to mem_rdt_i valid).
//
// Ports:
//   c_clk_i, c_rst_ni            clock, async active-low reset
//   start_i, dir_i, addr_i, len_i transfer request (dir_i: 0 read, 1 write)
//   abort_i                      cancel the active transfer
//   wdata_i, wvalid_i, wready_o  write-word stream
//   rdata_o, rvalid_o, rready_i  read-word stream
//   mem_en_o, mem_we_o, mem_addr_o, mem_wdt_o, mem_rdt_i  memory port
//   busy_o, done_o, err_o        status (done_o one-cycle pulse, err_o sticky)
//
// Optional feature: define QPROC_MEM_SEQ_TIMEOUT_EN to abandon a transfer
// (with err_o) after 65535 consecutive stalled cycles in WR_WAIT or RD_HOLD.

module qproc_mem_seq #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          c_clk_i,
    input  logic          c_rst_ni,
    input  logic          start_i,
    input  logic          dir_i,
    input  logic [AW-1:0] addr_i,
    input  logic [15:0]   len_i,
    input  logic          abort_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          wvalid_i,
    output logic          wready_o,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o,
    input  logic          rready_i,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdt_o,
    input  logic [DW-1:0] mem_rdt_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [2:0] {
        IDLE, WR_WAIT, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [15:0]   len_q;
    logic [15:0]   count;
    logic [2:0]    wait_cnt;
    logic          wr_hs;
    logic          rd_hs;
    logic          last;
    logic          timeout;
    logic [AW-1:0] cur_addr;

    assign wr_hs    = (state == WR_WAIT) && wvalid_i;
    assign rd_hs    = (state == RD_HOLD) && rready_i;
    assign last     = (count == len_q - 16'd1);
    // Address wraps naturally modulo 2^AW.
    assign cur_addr = addr_q + AW'(count);

    // Status and stream flags are pure state decodes, so reset forces them low.
    assign busy_o   = (state != IDLE);
    assign done_o   = (state == DONE);
    assign wready_o = (state == WR_WAIT);
    assign rvalid_o = (state == RD_HOLD);

    // Write words reach memory in the handshake cycle itself, so the memory
    // port is decoded combinationally and is zero whenever no access is made.
    assign mem_en_o   = wr_hs || (state == RD_ISSUE);
    assign mem_we_o   = wr_hs;
    assign mem_addr_o = mem_en_o ? cur_addr : '0;
    assign mem_wdt_o  = wr_hs ? wdata_i : '0;

`ifdef QPROC_MEM_SEQ_TIMEOUT_EN
    logic [15:0] idle_cnt;
    logic        stalled;

    assign stalled = ((state == WR_WAIT) && !wvalid_i) ||
                     ((state == RD_HOLD) && !rready_i);
    // Fires on the 65535th consecutive stalled cycle.
    assign timeout = stalled && (idle_cnt == 16'hFFFE);

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            idle_cnt <= '0;
        end else if (stalled && !timeout) begin
            idle_cnt <= idle_cnt + 16'd1;
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            count    <= '0;
            wait_cnt <= '0;
            rdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            if (start_i && (state != IDLE)) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // start_i outranks abort_i here.
                    if (start_i) begin
                        err_o  <= 1'b0;
                        addr_q <= addr_i;
                        len_q  <= len_i;
                        count  <= '0;
                        if (len_i == 16'd0) state <= DONE;
                        else if (dir_i)     state <= WR_WAIT;
                        else                state <= RD_ISSUE;
                    end
                end
                WR_WAIT: begin
                    if (wr_hs) begin
                        // The word is already on the memory port this cycle,
                        // so an abort still lets it complete.
                        count <= count + 16'd1;
                        if (abort_i)   state <= IDLE;
                        else if (last) state <= DONE;
                    end else if (abort_i) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= abort_i ? IDLE : RD_WAIT;
                end
                RD_WAIT: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (wait_cnt == 3'(RD_LAT - 1)) begin
                        rdata_o <= mem_rdt_i;
                        state   <= RD_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RD_HOLD: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (rd_hs) begin
                        count <= count + 16'd1;
                        state <= last ? DONE : RD_ISSUE;
                    end else if (timeout) begin
                        err_o <= 1'b1;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qproc_mem_seq.sv
// Testbench for qproc_mem_seq: table of transfers driven through a task, a
// memory model with RD_LAT read latency, a queue-based scoreboard checking
// every memory access and read word, and directed abort/reset sequences.

module tb_qproc_mem_seq;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    logic          c_clk_i;
    logic          c_rst_ni;
    logic          start_i;
    logic          dir_i;
    logic [AW-1:0] addr_i;
    logic [15:0]   len_i;
    logic          abort_i;
    logic [DW-1:0] wdata_i;
    logic          wvalid_i;
    logic          wready_o;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic          rready_i;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdt_o;
    logic [DW-1:0] mem_rdt_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    qproc_mem_seq #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .c_clk_i(c_clk_i), .c_rst_ni(c_rst_ni),
        .start_i(start_i), .dir_i(dir_i), .addr_i(addr_i), .len_i(len_i),
        .abort_i(abort_i),
        .wdata_i(wdata_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdt_o(mem_wdt_o), .mem_rdt_i(mem_rdt_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    initial c_clk_i = 1'b0;
    always #5 c_clk_i = ~c_clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    logic [47:0] wq[$];   // expected {addr, data} of memory writes
    logic [15:0] raq[$];  // expected memory read addresses
    logic [31:0] rq[$];   // expected read words on rdata_o

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event at %0t", nm, $time);
    endtask

    function automatic logic [31:0] wword(input int i);
        return {16'hC0DE, i[15:0]};
    endfunction

    // Memory model: read data for address a is a ^ 0xA5A5, valid RD_LAT
    // cycles after the access; filler value otherwise.
    logic [DW-1:0] pipe [0:3];
    always @(posedge c_clk_i) begin
        pipe[0] <= (mem_en_o && !mem_we_o) ? {16'h0000, mem_addr_o ^ 16'hA5A5} : 32'hDEAD_BEEF;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end
    assign mem_rdt_i = pipe[RD_LAT-1];

    // Scoreboard monitor, sampling away from the active edge.
    logic        prev_hold = 1'b0;
    logic [31:0] prev_rdata = '0;
    always @(negedge c_clk_i) begin
        if (c_rst_ni) begin
            if (mem_en_o && mem_we_o) begin
                if (wq.size() == 0) fail("wr_unexpected");
                else chk("wr_addr_data", {16'h0, mem_addr_o, mem_wdt_o}, {16'h0, wq.pop_front()});
            end
            if (mem_en_o && !mem_we_o) begin
                if (raq.size() == 0) fail("rd_unexpected");
                else chk("rd_addr", mem_addr_o, raq.pop_front());
            end
            if (rvalid_o && rready_i) begin
                if (rq.size() == 0) fail("rdata_unexpected");
                else chk("rdata", rdata_o, rq.pop_front());
            end
            if (prev_hold && rvalid_o) chk("rdata_stable", rdata_o, prev_rdata);
            if (done_o) done_cnt++;
            prev_hold  = rvalid_o && !rready_i;
            prev_rdata = rdata_o;
        end else begin
            prev_hold = 1'b0;
        end
    end

    typedef struct {
        logic        dir;
        logic [15:0] addr;
        logic [15:0] len;
        int          mode;     // 0: valid/ready held high, 1: gapped
        int          poke;     // cycle to pulse start_i while busy, -1 none
        int          exp_cyc;  // cycles from start to done_o, -1 unchecked
        logic        exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic run_txn(input vec_t v);
        int  k;
        int  idx;
        int  d0;
        bit  hs;
        logic [15:0] a;
        d0 = done_cnt;
        @(posedge c_clk_i); #1;
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.addr + 16'(i);
            if (v.dir) begin
                wq.push_back({a, wword(i)});
            end else begin
                raq.push_back(a);
                rq.push_back({16'h0000, a ^ 16'hA5A5});
            end
        end
        start_i = 1'b1; dir_i = v.dir; addr_i = v.addr; len_i = v.len;
        @(posedge c_clk_i); #1;
        start_i = 1'b0;
        idx = 0; k = 0;
        while (!done_o && k < 4000) begin
            if (k == v.poke) begin
                start_i = 1'b1; dir_i = 1'b1; addr_i = 16'h0BAD; len_i = 16'd7;
            end else begin
                start_i = 1'b0;
            end
            wvalid_i = v.dir && (v.mode == 0 || $urandom_range(0, 1) == 1);
            wdata_i  = wword(idx);
            rready_i = (v.mode == 0) || (k % 2 == 1);
            hs = wvalid_i && wready_o;
            @(posedge c_clk_i); #1;
            if (hs) idx++;
            k++;
        end
        start_i = 1'b0; wvalid_i = 1'b0; rready_i = 1'b0;
        chk("done_seen", done_o, 1);
        if (v.exp_cyc >= 0) chk("latency", k, v.exp_cyc);
        chk("err", err_o, v.exp_err);
        @(posedge c_clk_i); #1;
        chk("idle_after_done", {busy_o, done_o}, 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("queues_drained", wq.size() + rq.size() + raq.size(), 0);
    endtask

    int  d0;
    bit  bad;

    initial begin
        tbl[0] = '{1'b1, 16'h0010, 16'd3, 0, -1, 3,  1'b0};
        tbl[1] = '{1'b0, 16'h0020, 16'd2, 1, -1, -1, 1'b0};
        tbl[2] = '{1'b1, 16'hFFFE, 16'd3, 0, -1, 3,  1'b0};
        tbl[3] = '{1'b0, 16'hFFFF, 16'd2, 0, -1, 8,  1'b0};
        tbl[4] = '{1'b1, 16'h1234, 16'd5, 1, -1, -1, 1'b0};
        tbl[5] = '{1'b0, 16'h0100, 16'd3, 0, -1, 12, 1'b0};
        tbl[6] = '{1'b1, 16'h0300, 16'd0, 0, -1, 0,  1'b0};
        tbl[7] = '{1'b0, 16'h0040, 16'd2, 0, 3,  8,  1'b1};
        tbl[8] = '{1'b0, 16'h0400, 16'd0, 0, -1, 0,  1'b0};
        tbl[9] = '{1'b1, 16'h0080, 16'd2, 0, -1, 2,  1'b0};

        start_i = 0; dir_i = 0; addr_i = 0; len_i = 0; abort_i = 0;
        wdata_i = 0; wvalid_i = 0; rready_i = 0;
        c_rst_ni = 1'b1;
        #2 c_rst_ni = 1'b0;
        #10;
        chk("reset_ctrl", {busy_o, done_o, err_o, wready_o, rvalid_o, mem_en_o, mem_we_o}, 0);
        chk("reset_data", {mem_addr_o, mem_wdt_o}, 0);
        chk("reset_rdata", rdata_o, 0);
        @(posedge c_clk_i); #1;
        c_rst_ni = 1'b1;

        for (int t = 0; t < 9; t++) run_txn(tbl[t]);

        // Abort during RD_WAIT: read issued, its data never surfaces.
        d0 = done_cnt;
        @(posedge c_clk_i); #1;
        raq.push_back(16'h0050);
        start_i = 1; dir_i = 0; addr_i = 16'h0050; len_i = 16'd2; rready_i = 1;
        @(posedge c_clk_i); #1; start_i = 0;          // RD_ISSUE
        @(posedge c_clk_i); #1; abort_i = 1;          // RD_WAIT
        @(posedge c_clk_i); #1; abort_i = 0;
        chk("abort_rd_idle", {busy_o, rvalid_o}, 0);
        bad = 0;
        repeat (6) begin
            @(posedge c_clk_i); #1;
            if (rvalid_o || busy_o) bad = 1;
        end
        chk("abort_rd_quiet", bad, 0);
        chk("abort_rd_no_done", done_cnt - d0, 0);
        rready_i = 0;
        chk("abort_rd_queues", raq.size(), 0);

        // Abort together with a write handshake: that word still lands.
        d0 = done_cnt;
        wq.push_back({16'h0060, wword(0)});
        wq.push_back({16'h0061, wword(1)});
        start_i = 1; dir_i = 1; addr_i = 16'h0060; len_i = 16'd4;
        @(posedge c_clk_i); #1; start_i = 0;
        wvalid_i = 1; wdata_i = wword(0);
        @(posedge c_clk_i); #1;
        wdata_i = wword(1); abort_i = 1;
        @(posedge c_clk_i); #1;
        abort_i = 0; wvalid_i = 0;
        chk("abort_wr_idle", busy_o, 0);
        repeat (3) @(posedge c_clk_i);
        #1;
        chk("abort_wr_no_done", done_cnt - d0, 0);
        chk("abort_wr_queues", wq.size(), 0);

        // Reset in the middle of a write, with err_o set beforehand.
        d0 = done_cnt;
        wq.push_back({16'h0070, wword(0)});
        wq.push_back({16'h0071, wword(1)});
        start_i = 1; dir_i = 1; addr_i = 16'h0070; len_i = 16'd4;
        @(posedge c_clk_i); #1; start_i = 0;
        wvalid_i = 1; wdata_i = wword(0);
        @(posedge c_clk_i); #1; wdata_i = wword(1);
        @(posedge c_clk_i); #1;
        wvalid_i = 0; start_i = 1;
        @(posedge c_clk_i); #1; start_i = 0;
        chk("busy_start_err", {busy_o, err_o}, 2'b11);
        wvalid_i = 1; wdata_i = wword(2);
        #2 c_rst_ni = 0;
        #1;
        chk("midrst_ctrl", {busy_o, done_o, err_o, wready_o, rvalid_o, mem_en_o, mem_we_o}, 0);
        chk("midrst_data", {mem_addr_o, mem_wdt_o}, 0);
        chk("midrst_rdata", rdata_o, 0);
        @(posedge c_clk_i); #1;
        @(posedge c_clk_i); #1;
        chk("midrst_hold", {busy_o, mem_en_o, err_o}, 0);
        c_rst_ni = 1; wvalid_i = 0;
        repeat (3) @(posedge c_clk_i);
        #1;
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_queues", wq.size(), 0);
        run_txn(tbl[9]);

`ifdef QPROC_MEM_SEQ_TIMEOUT_EN
        begin
            int n;
            d0 = done_cnt;
            raq.push_back(16'h0090);
            @(posedge c_clk_i); #1;
            start_i = 1; dir_i = 0; addr_i = 16'h0090; len_i = 16'd1; rready_i = 0;
            @(posedge c_clk_i); #1; start_i = 0;
            n = 0;
            while (busy_o && n < 70000) begin
                @(posedge c_clk_i); #1;
                n++;
            end
            chk("timeout_idle", busy_o, 0);
            chk("timeout_err", err_o, 1);
            chk("timeout_no_done", done_cnt - d0, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
